// File: rtl/wl_ram_pkg.sv
// Shared definitions for the wl_* RAM family: collision-mode codes,
// clear-engine state encoding and a constant-width helper.
package wl_ram_pkg;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wl_ram_clr_fsm.sv
// Clear engine: walks every address once writing zero, owning the write
// port for exactly 2**AW cycles.
module wl_ram_clr_fsm
  import wl_ram_pkg::*;
#(
  parameter int unsigned AW         = 10,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic          clk,
  input  logic          rst_p,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  clr_state_e    state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // clr_req is only looked at in IDLE, so a request during a clear is dropped.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt == '1) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy     = (state == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/wl_sdpram_clr.sv
// Simple dual-port RAM with byte-lane writes, selectable read-during-write
// behaviour, optional gated output register and a hardware clear engine.
module wl_sdpram_clr
  import wl_ram_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned AW         = 10,
  parameter int unsigned NB         = 1,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned OREG       = 0,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic          clk,
  input  logic          rst_p,
  input  logic          wr_en,
  input  logic [NB-1:0] wr_be,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_regce,
  input  logic          clr_req,
  output logic [DW-1:0] rd_data,
  output logic          rd_vld,
  output logic          busy
);

  localparam int unsigned LW    = DW / NB;
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  wl_ram_clr_fsm #(
    .AW         (AW),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_clr_fsm (
    .clk      (clk),
    .rst_p    (rst_p),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic [NB-1:0] lane_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  always_comb begin
    lane_we   = '0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (clr_we) begin
      lane_we   = '1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (wr_en) begin
      lane_we = wr_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (lane_we[i]) mem[mem_waddr][i*LW +: LW] <= mem_wdata[i*LW +: LW];
    end
  end

  logic          rd_fire;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] rd_merged;

  assign rd_fire = rd_en & ~busy;

  // Write-first forwards the enabled lanes of the concurrent write; reads are
  // blocked while clearing, so only the user write can collide here.
  always_comb begin
    rd_word   = mem[rd_addr];
    rd_merged = rd_word;
    if (RDW_MODE == RDW_WRITE_FIRST && !clr_we && mem_waddr == rd_addr) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (lane_we[i]) rd_merged[i*LW +: LW] = mem_wdata[i*LW +: LW];
      end
    end
  end

  logic [DW-1:0] s1_data;
  logic          s1_vld;

  always_ff @(posedge clk) begin
    if (rst_p) begin
      s1_data <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= rd_fire;
      if (rd_fire) s1_data <= rd_merged;
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic [DW-1:0] s2_data;
      logic          s2_vld;

      always_ff @(posedge clk) begin
        if (rst_p) begin
          s2_data <= '0;
          s2_vld  <= 1'b0;
        end else begin
          s2_vld <= s1_vld & rd_regce;
          if (rd_regce) s2_data <= s1_data;
        end
      end

      assign rd_data = s2_data;
      assign rd_vld  = s2_vld;
    end else begin : g_noreg
      logic unused_regce;
      assign unused_regce = rd_regce;
      assign rd_data      = s1_data;
      assign rd_vld       = s1_vld;
    end
  endgenerate

endmodule
